// File: rtl/stack_mem_pkg.sv
// rtl/stack_mem_pkg.sv - shared sizes, state encoding and typedefs for the stack machine memory responder
package stack_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } mem_state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/stack_mem_array.sv
// rtl/stack_mem_array.sv - single-port byte storage, synchronous write, registered read-before-write
module stack_mem_array
#(
  parameter int ADDR_W = stack_mem_pkg::ADDR_W,
  parameter int DATA_W = stack_mem_pkg::DATA_W,
  parameter int DEPTH  = stack_mem_pkg::DEPTH
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; a program load overwrites what it needs.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // rdata samples the pre-write contents, giving read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/stack_mem_responder.sv
// rtl/stack_mem_responder.sv - program loader and memory responder for the stack machine core
// Optional write protection of the loaded image: STACK_MEM_WRITE_PROTECT_EN
module stack_mem_responder
#(
  parameter int ADDR_W = stack_mem_pkg::ADDR_W,
  parameter int DATA_W = stack_mem_pkg::DATA_W,
  parameter int DEPTH  = stack_mem_pkg::DEPTH
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  output logic [DATA_W-1:0] data_out,
  output logic              core_rst,
  output logic [ADDR_W:0]   prog_len,
  output logic              wr_viol
);

  import stack_mem_pkg::*;

  mem_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic              serve;
  logic              load_fire;
  logic              load_done;
  logic              wr_block;
  logic [ADDR_W-1:0] arr_addr;
  logic              arr_we;
  logic [DATA_W-1:0] arr_wdata;

  assign serve     = (state == SERVE);
  assign load_fire = !serve && load_valid && load_ready;
  // Leaving at the last slot keeps ptr from ever wrapping back onto byte 0.
  assign load_done = load_last || (ptr == ADDR_W'(DEPTH - 1));

`ifdef STACK_MEM_WRITE_PROTECT_EN
  assign wr_block = wr_en && ({1'b0, mem_addr} < prog_len);
`else
  assign wr_block = 1'b0;
`endif

  assign arr_addr  = serve ? mem_addr : ptr;
  assign arr_wdata = serve ? data_in  : load_data;
  assign arr_we    = load_fire || (serve && wr_en && !wr_block);

  stack_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .addr  (arr_addr),
    .we    (arr_we),
    .wdata (arr_wdata),
    .rd_en (serve),
    .rdata (data_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      ptr        <= '0;
      prog_len   <= '0;
      load_ready <= 1'b1;
      core_rst   <= 1'b1;
      wr_viol    <= 1'b0;
    end else begin
      wr_viol <= serve && wr_block;
      unique case (state)
        LOAD: begin
          if (load_fire) begin
            prog_len <= prog_len + (ADDR_W+1)'(1);
            if (load_done) begin
              state      <= SERVE;
              load_ready <= 1'b0;
              core_rst   <= 1'b0;
            end else begin
              ptr <= ptr + ADDR_W'(1);
            end
          end
        end
        SERVE: begin
          state <= SERVE;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_mem_responder.sv
// tb/tb_stack_mem_responder.sv - directed self-checking bench for stack_mem_responder
module tb_stack_mem_responder;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [7:0] mem_addr;
  logic [7:0] data_in;
  logic       wr_en;
  logic [7:0] data_out;
  logic       core_rst;
  logic [8:0] prog_len;
  logic       wr_viol;

  int checks = 0;
  int errors = 0;

  stack_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .mem_addr   (mem_addr),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .data_out   (data_out),
    .core_rst   (core_rst),
    .prog_len   (prog_len),
    .wr_viol    (wr_viol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_data  = b;
    load_last  = last;
    step();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    wr_en      = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    mem_addr = 8'h00; data_in = 8'h00; wr_en = 1'b0;
    step(); step();
    rst = 1'b0;

    check("rst_load_ready", load_ready, 1);
    check("rst_core_rst",   core_rst,   1);
    check("rst_data_out",   data_out,   0);
    check("rst_prog_len",   prog_len,   0);
    check("rst_wr_viol",    wr_viol,    0);

    // Core write strobe during LOAD must be ignored.
    wr_en = 1'b1; mem_addr = 8'h00; data_in = 8'h99;
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b0);
    check("load2_core_rst", core_rst, 1);
    check("load2_data_out", data_out, 0);
    load_byte(8'h33, 1'b1);
    load_valid = 1'b0; load_last = 1'b0; wr_en = 1'b0;
    check("load3_prog_len",   prog_len,   3);
    check("load3_core_rst",   core_rst,   0);
    check("load3_load_ready", load_ready, 0);

    mem_addr = 8'd1; step();
    check("rd_addr1", data_out, 8'h22);
    mem_addr = 8'd0; step();
    check("rd_addr0_no_load_wr", data_out, 8'h11);
    mem_addr = 8'd2; step();
    check("rd_addr2", data_out, 8'h33);

    mem_addr = 8'd10; data_in = 8'h5A; wr_en = 1'b1; step();
    data_in = 8'hA5; step();
    check("rbw_old_value", data_out, 8'h5A);
    check("rbw_no_viol",   wr_viol,  0);
    wr_en = 1'b0; step();
    check("rbw_new_value", data_out, 8'hA5);

    mem_addr = 8'd0; data_in = 8'hFF; wr_en = 1'b1; step();
    wr_en = 1'b0;
`ifdef STACK_MEM_WRITE_PROTECT_EN
    check("wp_viol_pulse", wr_viol, 1);
    step();
    check("wp_viol_end", wr_viol,  0);
    check("wp_mem0_kept", data_out, 8'h11);
`else
    check("nowp_viol", wr_viol, 0);
    step();
    check("nowp_viol_after", wr_viol,  0);
    check("nowp_mem0_written", data_out, 8'hFF);
`endif

    do_reset();
    check("srv_rst_core_rst",   core_rst,   1);
    check("srv_rst_load_ready", load_ready, 1);
    check("srv_rst_prog_len",   prog_len,   0);
    check("srv_rst_data_out",   data_out,   0);

    load_byte(8'hA0, 1'b0);
    load_byte(8'hA1, 1'b0);
    check("mid_prog_len2", prog_len, 2);
    do_reset();
    check("mid_rst_prog_len",   prog_len,   0);
    check("mid_rst_load_ready", load_ready, 1);
    check("mid_rst_core_rst",   core_rst,   1);
    load_byte(8'hB0, 1'b0);
    load_byte(8'hB1, 1'b0);
    load_byte(8'hB2, 1'b0);
    load_byte(8'hB3, 1'b1);
    load_valid = 1'b0; load_last = 1'b0;
    check("reload_prog_len", prog_len, 4);
    check("reload_core_rst", core_rst, 0);
    mem_addr = 8'd3; step();
    check("reload_rd3", data_out, 8'hB3);
    mem_addr = 8'd0; step();
    check("reload_rd0", data_out, 8'hB0);

    do_reset();
    for (int i = 0; i < 256; i++) begin
      load_byte(8'(i) ^ 8'h5A, 1'b0);
      if (i == 254) begin
        check("full_255_ready",    load_ready, 1);
        check("full_255_prog_len", prog_len,   255);
      end
    end
    check("full_prog_len",   prog_len,   256);
    check("full_load_ready", load_ready, 0);
    check("full_core_rst",   core_rst,   0);
    // An extra offered byte after the image is full must not land anywhere.
    load_byte(8'hEE, 1'b0);
    load_valid = 1'b0;
    mem_addr = 8'd255; step();
    check("full_rd255", data_out, 8'hA5);
    mem_addr = 8'd0; step();
    check("full_rd0_no_wrap", data_out, 8'h5A);
    check("full_prog_len_hold", prog_len, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_mem_responder.md
# stack_mem_responder

Memory responder for the stack machine's byte-wide memory port: it answers the core's address/write-data outputs with registered read data and performs writes. Before execution it accepts a program image over a byte-serial valid/ready load port and holds the core in reset until loading completes. It sits between the stack machine and the board or bench, replacing a passive memory model.

## Interface
Parameters:
- ADDR_W, 8, address width; matches the core's `mem_addr`
- DATA_W, 8, data width
- DEPTH, 256, words of storage; equals 2**ADDR_W

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  program byte offered
- load_data  in  DATA_W  program byte
- load_last  in  1  marks final program byte; qualified by load_valid
- load_ready  out  1  responder accepts a program byte
- mem_addr  in  ADDR_W  core address
- data_in  in  DATA_W  write data from the core
- wr_en  in  1  core write strobe
- data_out  out  DATA_W  read data to the core
- core_rst  out  1  active-high reset to the core; held until load done
- prog_len  out  ADDR_W+1  number of bytes loaded
- wr_viol  out  1  one-cycle pulse on a blocked write

## Operation
- FSM states: LOAD and SERVE. Reset enters LOAD.
- Reset values:
  - load_ready=1, core_rst=1, data_out=0, prog_len=0, wr_viol=0, load pointer=0.
  - Storage contents are not cleared.
- LOAD:
  - Handshake fires when load_valid && load_ready: mem[ptr] ← load_data, ptr++, prog_len++.
  - Transition to SERVE after a handshake with load_last=1, or after the handshake at ptr=DEPTH-1 (prog_len=256).
  - load_valid without load_ready is ignored. wr_en is ignored. data_out holds 0.
- SERVE:
  - load_ready=0 and core_rst=0; load inputs are ignored.
  - Every cycle: data_out ← mem[mem_addr].
  - If wr_en: mem[mem_addr] ← data_in.
  - A simultaneous read and write of the same address returns the old data (read-before-write).
  - SERVE is exited only by rst.
- Address arithmetic: ptr is ADDR_W bits and never wraps, because the FSM leaves LOAD at DEPTH-1. prog_len is ADDR_W+1 bits so it can represent 256.
- Reset mid-load: returns to LOAD with ptr=0 and prog_len=0. Previously written bytes remain but will be overwritten by the next load.
- Reset in SERVE: core_rst reasserts on the next edge and the responder reloads.

## Timing
- Load throughput: one byte per cycle while load_valid stays high.
- LOAD→SERVE: on the edge that accepts the last byte, the registered state, load_ready (→0) and core_rst (→0) all update together. The core's first cycle out of reset is the next cycle.
- Read latency: 1 cycle. The mem_addr sampled at edge N appears on data_out after edge N.
- Write: committed at the sampling edge. A read of the same address issued at the next edge returns the new data.
- wr_viol: registered, high for exactly the cycle after the blocked write.

## Configuration
- Macro `STACK_MEM_WRITE_PROTECT_EN`.
- Defined: SERVE-state writes with mem_addr < prog_len are dropped and pulse wr_viol. Reads are unaffected.
- Undefined: all SERVE writes are committed and wr_viol is tied 0. The port remains present.

## Structure
- Package `stack_mem_pkg`:
  - ADDR_W, DATA_W and DEPTH constants
  - `mem_state_t` enum {LOAD, SERVE}
  - `addr_t` / `data_t` typedefs
- Sub-module `stack_mem_array`: single-port storage with one synchronous write port and a registered read, read-before-write. The top level holds the FSM, pointer, protection check and output muxing.

## Test plan
- Reset, then load 3 bytes {0x11,0x22,0x33}, last on the 3rd → prog_len=3; core_rst falls on that edge; load_ready=0.
- SERVE read of addr 1 → data_out=0x22 one cycle later; addr 200 (unloaded) is not checked.
- Write 0xA5 to addr 10 with a same-cycle read of addr 10 → old value returned; read on the next cycle → 0xA5.
- Load 256 bytes with load_last never asserted → SERVE entered after byte 256, prog_len=256, no pointer wrap.
- With the macro, write 0xFF to addr 0 after a 3-byte load → mem[0] stays 0x11 and wr_viol pulses once. Without the macro → mem[0]=0xFF and wr_viol stays 0.
- Assert rst after 2 of 4 load bytes → prog_len=0, load_ready=1, core_rst=1. A fresh 4-byte load then completes with prog_len=4.
